u_xmit_sched: RTL
=================

# u_xmit_sched

Round-robin transmit scheduler that shares one `u_xmit` UART transmitter among `N_REQ` byte producers. It arbitrates between pending requests and launches one frame at a time with a one-cycle `xmitH` pulse. It tracks the frame through the transmitter's `xmit_doneH` status and returns a per-requester acknowledge when the frame completes. It sits between the UART's internal byte sources and `u_xmit`; a watchdog flags a transmitter that fails to start a frame.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TMO`, default 4: maximum number of WAIT_LOW cycles before a launch is declared failed.

- `sys_clk`, in, 1: system clock; single clock domain.
- `sys_rst_l`, in, 1: reset, asynchronous, active-low.
- `enaH`, in, 1: scheduler enable; gates new grants only.
- `reqH`, in, `N_REQ`: request per requester; held high until the matching `ackH`.
- `req_dataH`, in, `8*N_REQ`: byte per requester; requester k uses bits `[8k+7:8k]`.
- `ackH`, out, `N_REQ`: one-cycle one-hot pulse when the requester's frame has finished or aborted.
- `xmitH`, out, 1: to `u_xmit.xmitH`; one-cycle start pulse.
- `xmit_dataH`, out, 8: to `u_xmit.xmit_dataH`; registered, stable from launch until the next launch.
- `xmit_doneH`, in, 1: from `u_xmit`; high while the transmitter is idle, low during a frame.
- `busyH`, out, 1: high in every state except IDLE.
- `grantH`, out, `clog2(N_REQ)`: index of the current or last granted requester.
- `errH`, out, 1: sticky watchdog error flag.
- `err_clrH`, in, 1: clears `errH`.

## Operation
- All outputs are registered. Reset values: `ackH`=0, `xmitH`=0, `xmit_dataH`=0, `busyH`=0, `grantH`=0, `errH`=0. The round-robin pointer resets to 0 (requester 0 has highest priority), and the state resets to IDLE.
- IDLE:
  - A grant is made only when `enaH`=1, `xmit_doneH`=1, and at least one eligible request is present.
  - Eligible requests are `reqH & ~ackH`. The mask suppresses the duplicate grant a requester would otherwise get in the cycle its ack is visible.
  - The winner is the first eligible index at or after the pointer, searching upward with wrap-around.
  - On a grant: `xmitH`<=1, `xmit_dataH`<=winner's byte, `grantH`<=winner, watchdog counter cleared, next state WAIT_LOW.
- WAIT_LOW:
  - `xmitH`<=0, so the pulse lasts exactly one cycle.
  - If `xmit_doneH`=0, the next state is WAIT_HIGH.
  - Otherwise the counter increments. When the counter reaches `TMO`: `errH`<=1, `ackH[grantH]`<=1, pointer<=`grantH`+1 mod `N_REQ`, next state IDLE.
- WAIT_HIGH:
  - The block waits for `xmit_doneH`=1. There is no timeout here, since the frame length is owned by `u_xmit`.
  - When `xmit_doneH`=1: `ackH[grantH]`<=1, pointer<=`grantH`+1 mod `N_REQ`, next state IDLE.
- `ackH` is cleared in every cycle in which it was not just set.
- If a requester drops `reqH` mid-frame, the frame still completes and the ack is still pulsed (the requester may ignore it).
- With `enaH`=0, an in-flight frame completes normally; only new grants are blocked.
- `errH` is set by a watchdog expiry and cleared by `err_clrH`. If both occur in the same cycle, set wins.
- Asserting `sys_rst_l` mid-frame returns every register to its reset value immediately, with no ack. `u_xmit` shares the same reset.

## Timing
- Request seen in IDLE in cycle t: `xmitH`=1 and `xmit_dataH` valid in t+1; `u_xmit` drives `xmit_doneH` low from t+2.
- At t+1, `xmit_doneH` is still high, so the watchdog counts that cycle. A normal launch exits WAIT_LOW at the end of t+2.
- `xmit_doneH` rising in cycle d: `ackH` is high in d+1, and that cycle is also the next IDLE arbitration cycle.
- Back-to-back frames therefore have a 2-cycle scheduler overhead on top of the `u_xmit` frame time.

## Structure
- State encodings (IDLE, WAIT_LOW, WAIT_HIGH; 2 bits) are shared constants added to `inc.h` next to the `x_*` transmitter states.
- One sub-module, `rr_pick`: a combinational round-robin selector. Inputs are the request vector and the pointer; outputs are the winner index and a valid flag.
- The FSM, watchdog, and output registers live in `u_xmit_sched`. Instantiation with `u_xmit` is done at UART top level.

## Test plan
- Single request: `reqH`=4'b0010 with byte 0xA5 → `xmitH` is a one-cycle pulse with `xmit_dataH`=0xA5 and `grantH`=1; the `u_xmit` line carries 0xA5 LSB-first; `ackH`=4'b0010 for one cycle, one cycle after `xmit_doneH` rises.
- Fairness: `reqH`=4'b1111 held continuously, bytes 0x10..0x13 → grants occur in order 0,1,2,3,0. There is no duplicate grant of the just-acked requester, and exactly one ack per frame.
- Pointer wrap: the last grant was 3, then `reqH`=4'b1001 → requester 0 wins next; after that, requester 3 wins.
- Watchdog: a stub holds `xmit_doneH`=1 after launch → `errH`=1 after 4 WAIT_LOW cycles, `ackH` pulses, and the block returns to IDLE. `err_clrH` then clears `errH`. With `err_clrH` asserted in the same cycle as an expiry, `errH` ends up 1.
- Enable and reset: dropping `enaH` mid-frame → the current frame still acks and no new `xmitH` is issued. Pulsing `sys_rst_l` low mid-frame → all outputs are 0 immediately, with no ack; after release, requester 0 wins arbitration first.

Source files
------------

// File: rtl/u_xmit_sched_pkg.sv
// Shared scheduler state encodings and sizing helper for the u_xmit round-robin
// transmit scheduler.
package u_xmit_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOW  = 2'd1,
      WAIT_HIGH = 2'd2
   } schedState_t;

   // Index width for a requester count; never below one bit.
   function automatic int ptrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/u_xmit_sched_if.sv
// Requester bus and u_xmit launch/status bus seen by the transmit scheduler.
interface u_xmit_sched_if #(
   parameter int N_REQ = 4
) ();
   logic [N_REQ-1:0]   reqH;
   logic [8*N_REQ-1:0] req_dataH;
   logic [N_REQ-1:0]   ackH;
   logic               xmitH;
   logic [7:0]         xmit_dataH;
   logic               xmit_doneH;

   modport slave (
      input  reqH, req_dataH, xmit_doneH,
      output ackH, xmitH, xmit_dataH
   );

   modport master (
      output reqH, req_dataH, xmit_doneH,
      input  ackH, xmitH, xmit_dataH
   );
endinterface

// File: rtl/u_xmit_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching upward with wrap-around.
module u_xmit_sched_rr_pick
   import u_xmit_sched_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int PW    = ptrWidth(N_REQ)
) (
   input  logic [N_REQ-1:0] reqVec,
   input  logic [PW-1:0]    ptr,
   output logic [PW-1:0]    winner,
   output logic             valid
);

   logic [N_REQ-1:0] hitAt;
   logic [PW-1:0]    idxAt [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : gOffset
      logic [PW:0] sum;
      assign sum        = {1'b0, ptr} + (PW+1)'(gi);
      assign idxAt[gi]  = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
      assign hitAt[gi]  = reqVec[idxAt[gi]];
   end

   // Scan from the far offset down so the smallest offset from ptr wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (hitAt[i]) begin
            valid  = 1'b1;
            winner = idxAt[i];
         end
      end
   end

endmodule

// File: rtl/u_xmit_sched.sv
// Round-robin scheduler sharing one u_xmit transmitter among N_REQ byte
// producers, with a launch watchdog and per-requester completion acks.
module u_xmit_sched
   import u_xmit_sched_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int TMO   = 4,
   localparam int PW    = ptrWidth(N_REQ),
   localparam int CW    = $clog2(TMO + 1)
) (
   input  logic          sys_clk,
   input  logic          sys_rst_l,
   input  logic          enaH,
   input  logic          err_clrH,
   output logic          busyH,
   output logic [PW-1:0] grantH,
   output logic          errH,
   u_xmit_sched_if.slave bus
);

   schedState_t      stateReg, stateNext;
   logic [PW-1:0]    ptrReg, ptrNext;
   logic [PW-1:0]    grantReg, grantNext;
   logic [CW-1:0]    cntReg, cntNext;
   logic             xmitReg, xmitNext;
   logic [7:0]       dataReg, dataNext;
   logic [N_REQ-1:0] ackReg, ackNext;
   logic             busyReg, busyNext;
   logic             errReg, errNext;

   logic [N_REQ-1:0] eligible;
   logic [PW-1:0]    pickIdx;
   logic             pickValid;

   // A requester whose ack is on the bus this cycle still holds reqH; mask it.
   assign eligible = bus.reqH & ~ackReg;

   u_xmit_sched_rr_pick #(.N_REQ(N_REQ)) uPick (
      .reqVec (eligible),
      .ptr    (ptrReg),
      .winner (pickIdx),
      .valid  (pickValid)
   );

   always_comb begin
      logic          finish;
      logic          expire;
      logic [CW-1:0] cntInc;

      stateNext = stateReg;
      ptrNext   = ptrReg;
      grantNext = grantReg;
      cntNext   = cntReg;
      xmitNext  = 1'b0;
      dataNext  = dataReg;
      ackNext   = '0;
      errNext   = errReg;
      finish    = 1'b0;
      expire    = 1'b0;
      cntInc    = cntReg + 1'b1;

      case (stateReg)
         IDLE: begin
            if (enaH && bus.xmit_doneH && pickValid) begin
               xmitNext  = 1'b1;
               dataNext  = bus.req_dataH[{pickIdx, 3'b000} +: 8];
               grantNext = pickIdx;
               cntNext   = '0;
               stateNext = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!bus.xmit_doneH) begin
               stateNext = WAIT_HIGH;
            end else begin
               cntNext = cntInc;
               if (cntInc == CW'(TMO)) begin
                  expire = 1'b1;
                  finish = 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (bus.xmit_doneH) begin
               finish = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase

      if (finish) begin
         ackNext[grantReg] = 1'b1;
         ptrNext           = (grantReg == PW'(N_REQ - 1)) ? '0 : grantReg + 1'b1;
         stateNext         = IDLE;
      end

      // A watchdog expiry beats a simultaneous clear.
      if (expire) begin
         errNext = 1'b1;
      end else if (err_clrH) begin
         errNext = 1'b0;
      end

      busyNext = (stateNext != IDLE);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         stateReg <= IDLE;
         ptrReg   <= '0;
         grantReg <= '0;
         cntReg   <= '0;
         xmitReg  <= 1'b0;
         dataReg  <= '0;
         ackReg   <= '0;
         busyReg  <= 1'b0;
         errReg   <= 1'b0;
      end else begin
         stateReg <= stateNext;
         ptrReg   <= ptrNext;
         grantReg <= grantNext;
         cntReg   <= cntNext;
         xmitReg  <= xmitNext;
         dataReg  <= dataNext;
         ackReg   <= ackNext;
         busyReg  <= busyNext;
         errReg   <= errNext;
      end
   end

   assign bus.ackH       = ackReg;
   assign bus.xmitH      = xmitReg;
   assign bus.xmit_dataH = dataReg;
   assign busyH          = busyReg;
   assign grantH         = grantReg;
   assign errH           = errReg;

endmodule
